// File: rtl/inv_keyexp_seq.sv
// inv_keyexp_seq: iterative inverse AES key schedule for the decryption path.
// Takes the last NK words of the expanded key and regenerates the schedule
// backwards, one word per cycle, emitting round keys NR down to 0.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   i_valid  last-round key material valid
//   o_ready  high in IDLE only; key material accepted on i_valid && o_ready
//   i_key    w[4*(NR+1)-NK] in the MSBs down to w[4*NR+3] in the LSBs
//   o_valid  round key valid
//   i_ready  downstream accepts round key
//   o_rkey   round key r: w[4r] in the MSBs down to w[4r+3] in the LSBs
//   o_round  index r of the round key on o_rkey
module inv_keyexp_seq #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4,
  parameter int NR   = NK + 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NK*WORD-1:0]   i_key,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NB*WORD-1:0]   o_rkey,
  output logic [3:0]           o_round
);

  localparam int JW = $clog2(4 * (NR + 1));
  localparam logic [JW:0] NK_W = (JW + 1)'(NK);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP
  } state_e;

  state_e              state_q;
  logic [WORD-1:0]     win_q [NK];
  logic [JW-1:0]       j_q;
  logic                o_ready_q;
  logic                o_valid_q;
  logic [NB*WORD-1:0]  o_rkey_q;
  logic [3:0]          o_round_q;

  logic [JW:0]         i_w;
  logic                is_rot;
  logic                is_sub;
  logic [WORD-1:0]     sub_in;
  logic [WORD-1:0]     sub_out;
  logic [WORD-1:0]     t_word;
  logic [WORD-1:0]     new_word_d;
  logic [JW-1:0]       j_dec;
  logic                step_done;
  logic                next_aligned;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254 by square-and-multiply) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int unsigned k = 0; k < 8; k++) begin
      inv = gf_mul(inv, inv);
      if (k != 7) inv = gf_mul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [JW:0] idx);
    logic [7:0] rc;
    case (int'(idx))
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end

  // Backward word: w[j-1] = w[j+NK-1] ^ T(w[j+NK-2]) with i = j+NK-1.
  always_comb begin
    i_w          = {1'b0, j_q} + (JW + 1)'(NK - 1);
    is_rot       = (i_w % NK_W) == '0;
    is_sub       = (NK == 8) && ((i_w % NK_W) == (JW + 1)'(4));
    sub_in       = is_rot ? {win_q[NK-2][23:0], win_q[NK-2][31:24]} : win_q[NK-2];
    if (is_rot)      t_word = sub_out ^ {rcon(i_w / NK_W), 24'h000000};
    else if (is_sub) t_word = sub_out;
    else             t_word = win_q[NK-2];
    new_word_d   = win_q[NK-1] ^ t_word;
    j_dec        = j_q - JW'(1);
    step_done    = j_dec == JW'({o_round_q, 2'b00});
    next_aligned = j_q == JW'({o_round_q - 4'd1, 2'b00});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      j_q       <= '0;
      o_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_rkey_q  <= '0;
      o_round_q <= '0;
      for (int unsigned k = 0; k < NK; k++) win_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (o_ready_q && i_valid) begin
            for (int unsigned k = 0; k < NK; k++) win_q[k] <= i_key[(NK-1-k)*WORD +: WORD];
            j_q       <= JW'(4 * (NR + 1) - NK);
            o_round_q <= 4'(NR);
            // Round NR is always the last four loaded words.
            o_rkey_q  <= i_key[NB*WORD-1:0];
            o_valid_q <= 1'b1;
            o_ready_q <= 1'b0;
            state_q   <= EMIT;
          end else begin
            o_ready_q <= 1'b1;
          end
        end
        EMIT: begin
          if (i_ready) begin
            if (o_round_q == '0) begin
              o_valid_q <= 1'b0;
              o_ready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              o_round_q <= o_round_q - 4'd1;
              // With NK=8 the next key already sits at the window head; emit it
              // directly instead of stepping past it.
              if (next_aligned) begin
                o_rkey_q <= {win_q[0], win_q[1], win_q[2], win_q[3]};
              end else begin
                o_valid_q <= 1'b0;
                state_q   <= STEP;
              end
            end
          end
        end
        STEP: begin
          win_q[0] <= new_word_d;
          for (int unsigned k = 1; k < NK; k++) win_q[k] <= win_q[k-1];
          j_q <= j_dec;
          if (step_done) begin
            o_rkey_q  <= {new_word_d, win_q[0], win_q[1], win_q[2]};
            o_valid_q <= 1'b1;
            state_q   <= EMIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_rkey  = o_rkey_q;
  assign o_round = o_round_q;

endmodule
